// File: rtl/mem_fabric.sv
// Single-master, N-slave interconnect for the picorv32 native memory bus.
// Decodes the slave index, routes strobes and read data, and generates m_ready with error reporting.
module mem_fabric #(
  parameter int                      NUM_SLAVES = 8,
  parameter int                      SEL_LO     = 12,
  parameter int                      SEL_W      = 4,
  parameter logic [4*NUM_SLAVES-1:0] WAIT       = {NUM_SLAVES{4'd0}},
  parameter int                      TIMEOUT    = 255,
  parameter logic [31:0]             ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       m_valid,
  input  logic [31:0]                m_addr,
  input  logic [31:0]                m_wdata,
  input  logic [3:0]                 m_wstrb,
  output logic                       m_ready,
  output logic [31:0]                m_rdata,
  output logic [NUM_SLAVES-1:0]      s_sel,
  output logic [4*NUM_SLAVES-1:0]    s_wstrb,
  input  logic [32*NUM_SLAVES-1:0]   s_rdata,
  input  logic [NUM_SLAVES-1:0]      s_ready,
  output logic                       err_irq,
  output logic [31:0]                err_addr,
  input  logic                       err_clr
);

  localparam logic [3:0] WAIT_HS = 4'd15;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [15:0]        tmo_q, tmo_d;
  logic [SEL_W-1:0]   idx_q;
  logic [SEL_W-1:0]   idx_d;
  logic [SEL_W-1:0]   cur_idx;
  logic [NUM_SLAVES-1:0] hit;
  logic [3:0]         cur_wait;
  logic [31:0]        cur_sdata;
  logic               cur_mapped;
  logic               cur_ready;
  logic               rd_err;
  logic               err_set;
  logic               err_irq_q;
  logic [31:0]        err_addr_q;

  // Write data is broadcast to the slaves outside this block.
  logic unused_wdata;
  assign unused_wdata = ^m_wdata;

  assign idx_d   = m_addr[SEL_LO +: SEL_W];
  assign cur_idx = (state_q == ST_IDLE) ? idx_d : idx_q;

  // Index lookup as a compare-per-slave: unmapped indices simply match nothing.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    hit       = '0;
    cur_wait  = 4'd0;
    cur_sdata = 32'd0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (cur_idx == SEL_W'(i)) begin
        hit[i]    = 1'b1;
        cur_wait  = WAIT[4*i +: 4];
        cur_sdata = s_rdata[32*i +: 32];
      end
    end
  end

  assign cur_mapped = |hit;
  assign cur_ready  = |(s_ready & hit);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    m_ready = 1'b0;
    rd_err  = 1'b0;
    err_set = 1'b0;
    if (!rst) begin
      unique case (state_q)
        ST_IDLE: begin
          if (m_valid) begin
            if (!cur_mapped) begin
              m_ready = 1'b1;
              rd_err  = 1'b1;
              err_set = 1'b1;
              state_d = ST_DONE;
            end else if (cur_wait == 4'd0) begin
              m_ready = 1'b1;
              state_d = ST_DONE;
            end else if (cur_wait != WAIT_HS) begin
              cnt_d   = cur_wait - 4'd1;
              state_d = ST_WAIT;
            end else if (cur_ready) begin
              m_ready = 1'b1;
              state_d = ST_DONE;
            end else begin
              tmo_d   = 16'(TIMEOUT - 1);
              state_d = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!m_valid) begin
            state_d = ST_IDLE;
          end else if (cur_wait != WAIT_HS) begin
            if (cnt_q == 4'd0) begin
              m_ready = 1'b1;
              state_d = ST_DONE;
            end else begin
              cnt_d = cnt_q - 4'd1;
            end
          end else if (cur_ready) begin
            m_ready = 1'b1;
            state_d = ST_DONE;
          end else if (tmo_q == 16'd0) begin
            m_ready = 1'b1;
            rd_err  = 1'b1;
            err_set = 1'b1;
            state_d = ST_DONE;
          end else begin
            tmo_d = tmo_q - 16'd1;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Selects drop in DONE so back-to-back accesses always see a gap.
  assign s_sel   = (!rst && m_valid && state_q != ST_DONE) ? hit : '0;
  assign m_rdata = m_ready ? (rd_err ? ERR_DATA : cur_sdata) : 32'd0;

  always_comb begin
    s_wstrb = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (s_sel[i]) s_wstrb[4*i +: 4] = m_wstrb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      tmo_q      <= 16'd0;
      idx_q      <= '0;
      err_irq_q  <= 1'b0;
      err_addr_q <= 32'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      if (state_q == ST_IDLE) idx_q <= idx_d;
      if (err_set) begin
        err_irq_q  <= 1'b1;
        err_addr_q <= m_addr;
      end else if (err_clr) begin
        err_irq_q <= 1'b0;
      end
    end
  end

  assign err_irq  = err_irq_q;
  assign err_addr = err_addr_q;

endmodule

// File: tb/tb_mem_fabric.sv
// Self-checking bench for mem_fabric: 4 slaves with waits {15,2,1,0}, TIMEOUT 8.
// Expected behaviour comes from a per-access latency/data model derived from the decode and wait rules.
module tb_mem_fabric;

  localparam int          NS   = 4;
  localparam int          TMO  = 8;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
  localparam logic [15:0] WCFG = {4'd15, 4'd2, 4'd1, 4'd0};

  logic        clk;
  logic        rst;
  logic        m_valid;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_ready;
  logic [31:0] m_rdata;
  logic [NS-1:0]    s_sel;
  logic [4*NS-1:0]  s_wstrb;
  logic [32*NS-1:0] s_rdata;
  logic [NS-1:0]    s_ready;
  logic        err_irq;
  logic [31:0] err_addr;
  logic        err_clr;

  mem_fabric #(
    .NUM_SLAVES(NS),
    .SEL_LO    (12),
    .SEL_W     (4),
    .WAIT      (WCFG),
    .TIMEOUT   (TMO),
    .ERR_DATA  (ERRD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .m_valid (m_valid),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_wstrb (m_wstrb),
    .m_ready (m_ready),
    .m_rdata (m_rdata),
    .s_sel   (s_sel),
    .s_wstrb (s_wstrb),
    .s_rdata (s_rdata),
    .s_ready (s_ready),
    .err_irq (err_irq),
    .err_addr(err_addr),
    .err_clr (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          ws [NS] = '{0, 1, 2, 15};
  logic [31:0] sd [NS];
  logic        mdl_irq;
  logic [31:0] mdl_eaddr;

  assign s_rdata = {sd[3], sd[2], sd[1], sd[0]};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic new_data();
    for (int i = 0; i < NS; i++) sd[i] = $urandom;
  endtask

  // One complete access. rise = first cycle s_ready[3] is high; clr0 pulses err_clr in cycle 0.
  task automatic access(input logic [31:0] addr, input logic [3:0] wstrb, input int rise, input bit clr0);
    int          idx;
    int          lat;
    bit          mapped;
    bit          err;
    logic [31:0] data;
    logic [3:0]  sel;
    logic [15:0] ws_exp;
    logic [31:0] wd;
    idx    = int'(addr[15:12]);
    mapped = idx < NS;
    err    = 1'b0;
    if (!mapped) begin
      lat = 0; data = ERRD; err = 1'b1;
    end else if (ws[idx] != 15) begin
      lat = ws[idx]; data = sd[idx];
    end else if (rise <= TMO) begin
      lat = rise; data = sd[idx];
    end else begin
      lat = TMO; data = ERRD; err = 1'b1;
    end
    sel = 4'd0;
    if (mapped) sel[idx] = 1'b1;
    ws_exp = '0;
    for (int i = 0; i < NS; i++) if (sel[i]) ws_exp[4*i +: 4] = wstrb;
    wd = $urandom;
    for (int cyc = 0; cyc <= lat; cyc++) begin
      @(negedge clk);
      m_valid    = 1'b1;
      m_addr     = addr;
      m_wdata    = wd;
      m_wstrb    = wstrb;
      s_ready    = 4'($urandom) & 4'b0111;
      s_ready[3] = (cyc >= rise);
      err_clr    = clr0 && (cyc == 0);
      #1;
      check("s_sel", 32'(s_sel), 32'(sel));
      check("s_wstrb", 32'(s_wstrb), 32'(ws_exp));
      check("m_ready", 32'(m_ready), 32'(cyc == lat));
      check("m_rdata", m_rdata, (cyc == lat) ? data : 32'd0);
      if (cyc == lat && err) begin
        mdl_irq   = 1'b1;
        mdl_eaddr = addr;
      end else if (err_clr) begin
        mdl_irq = 1'b0;
      end
    end
    @(negedge clk);
    m_valid = 1'b0;
    err_clr = 1'b0;
    s_ready = '0;
    #1;
    check("done_sel", 32'(s_sel), 32'd0);
    check("done_ready", 32'(m_ready), 32'd0);
    check("err_irq", 32'(err_irq), 32'(mdl_irq));
    check("err_addr", err_addr, mdl_eaddr);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    err_clr = 1'b1;
    mdl_irq = 1'b0;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    check("clr_irq", 32'(err_irq), 32'(mdl_irq));
  endtask

  initial begin
    rst = 1'b1; m_valid = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    s_ready = '0; err_clr = 1'b0;
    mdl_irq = 1'b0; mdl_eaddr = '0;
    new_data();
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", 32'(m_ready), 32'd0);
    check("rst_sel", 32'(s_sel), 32'd0);
    check("rst_wstrb", 32'(s_wstrb), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_irq", 32'(err_irq), 32'd0);
    check("rst_eaddr", err_addr, 32'd0);
    check("rst_rdata", m_rdata, 32'd0);

    // Zero-wait read, one-wait write, handshake, timeout.
    new_data(); sd[0] = 32'h0000_1234;
    access(32'h0000_0004, 4'b0000, 99, 1'b0);
    new_data();
    access(32'h0000_1000, 4'b0011, 99, 1'b0);
    new_data();
    access(32'h0000_3000, 4'b0000, 5, 1'b0);
    new_data();
    access(32'h0000_3010, 4'b0000, 1000, 1'b0);

    // Unmapped with a coincident clear: the set wins; then a lone clear.
    pulse_clr();
    new_data();
    access(32'h0000_7000, 4'b0000, 99, 1'b1);
    pulse_clr();

    // Handshake exactly at the timeout cycle and aliased address bits.
    new_data();
    access(32'hABCD_3FFC, 4'b1111, TMO, 1'b0);
    new_data();
    access(32'h5550_2008, 4'b1000, 99, 1'b0);

    // Master abandons a handshake access: no ready, no error.
    @(negedge clk);
    m_valid = 1'b1; m_addr = 32'h0000_3020; m_wstrb = 4'b0000; s_ready = '0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      if (cyc > 0) @(negedge clk);
      #1;
      check("abort_sel", 32'(s_sel), 32'h8);
      check("abort_ready", 32'(m_ready), 32'd0);
    end
    @(negedge clk);
    m_valid = 1'b0;
    #1;
    check("abort_idle_sel", 32'(s_sel), 32'd0);
    new_data();
    access(32'h0000_1004, 4'b0101, 99, 1'b0);

    // Reset in cycle 1 of a two-wait access, with the error flag set beforehand.
    new_data();
    access(32'h0000_9000, 4'b0000, 99, 1'b0);
    @(negedge clk);
    m_valid = 1'b1; m_addr = 32'h0000_2000; m_wstrb = 4'b0110;
    #1;
    check("pre_rst_sel", 32'(s_sel), 32'h4);
    check("pre_rst_ready", 32'(m_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(m_ready), 32'd0);
    check("mid_rst_sel", 32'(s_sel), 32'd0);
    check("mid_rst_wstrb", 32'(s_wstrb), 32'd0);
    check("mid_rst_rdata", m_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0; m_valid = 1'b0;
    mdl_irq = 1'b0; mdl_eaddr = '0;
    #1;
    check("post_rst_irq", 32'(err_irq), 32'd0);
    check("post_rst_eaddr", err_addr, 32'd0);
    check("post_rst_ready", 32'(m_ready), 32'd0);
    new_data();
    access(32'h0000_0010, 4'b0000, 99, 1'b0);

    // Random accesses across mapped, unmapped and aliased addresses.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      a = $urandom;
      a[15:12] = 4'($urandom_range(0, 5));
      new_data();
      access(a, 4'($urandom), $urandom_range(0, 11), $urandom_range(0, 3) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_fabric.md
# mem_fabric

Parametrised single-master, N-slave interconnect for the picorv32 native memory bus. Decodes an address field into one-hot slave selects, gates write strobes, muxes read data, and generates `m_ready` from a per-slave wait policy: fixed wait states or slave handshake. Handshake slaves are bounded by a timeout. It adds unmapped-address and timeout bus errors with a latched error address and a sticky IRQ. It replaces the hand-written chip-select, valid-register and ready/rdata logic in the SoC top level.

## Interface
- `NUM_SLAVES`, 8: number of slave ports, 1..16.
- `SEL_LO`, 12: low bit of the decode field.
- `SEL_W`, 4: width of the decode field `m_addr[SEL_LO+SEL_W-1:SEL_LO]`. 2^SEL_W ≥ NUM_SLAVES.
- `WAIT`, {NUM_SLAVES{4'd0}}: packed 4 bits per slave; slave i uses `WAIT[4i+3:4i]`. 0..14 = fixed wait states; 15 = wait for `s_ready[i]`.
- `TIMEOUT`, 255: maximum wait cycles for a handshake slave, 1..65535.
- `ERR_DATA`, 32'hDEAD_BEEF: read data returned on an error completion.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `m_valid` in 1: master request.
- `m_addr` in 32: byte address.
- `m_wdata` in 32: write data.
- `m_wstrb` in 4: byte strobes; 0 = read.
- `m_ready` out 1: one-cycle completion pulse.
- `m_rdata` out 32: read data, valid only while `m_ready` = 1.
- `s_sel` out NUM_SLAVES: one-hot slave select.
- `s_wstrb` out 4*NUM_SLAVES: per-slave strobes, equal to `m_wstrb` when selected, else 0.
- `s_rdata` in 32*NUM_SLAVES: slave read data, packed.
- `s_ready` in NUM_SLAVES: slave ready; sampled only when `WAIT` = 15.
- `err_irq` out 1: sticky error flag.
- `err_addr` out 32: address of the most recent error.
- `err_clr` in 1: clears `err_irq`.

## Operation
- Decode: `idx = m_addr[SEL_LO+SEL_W-1:SEL_LO]`.
  - Address bits outside the field are ignored, so slaves alias.
  - `idx ≥ NUM_SLAVES` is unmapped.
- `s_sel[idx]` = `m_valid` && mapped && state ≠ DONE. `s_sel` is combinational and held for the whole access.
- The master address and write data are broadcast to all slaves externally. The fabric routes strobes only.
- FSM states: IDLE, WAIT, DONE.
- IDLE, `m_valid` = 1:
  - Unmapped address: `m_ready` = 1 and `m_rdata` = ERR_DATA in the same cycle. Error is logged. Go to DONE.
  - `WAIT` = 0: `m_ready` = 1 and `m_rdata` = `s_rdata[idx]` in the same cycle. Go to DONE.
  - `WAIT` = n (1..14): load `cnt` = n − 1. Go to WAIT.
  - `WAIT` = 15 and `s_ready[idx]` = 1: complete in the same cycle. Go to DONE.
  - `WAIT` = 15 and `s_ready[idx]` = 0: load `tmo` = TIMEOUT − 1. Go to WAIT.
- WAIT, fixed-wait slave:
  - `cnt` = 0: complete with `s_rdata[idx]`. Go to DONE.
  - Otherwise decrement `cnt`.
- WAIT, handshake slave:
  - `s_ready[idx]` = 1: complete with slave data. Go to DONE.
  - Else `tmo` = 0: complete with ERR_DATA, log error, go to DONE.
  - Otherwise decrement `tmo`.
- WAIT, `m_valid` drops: abort to IDLE. No `m_ready`, no error.
- DONE: one dead cycle with no selects and no ready. Return to IDLE. This guarantees `s_sel` deasserts between back-to-back accesses.
- Error log:
  - `err_addr` ← `m_addr`.
  - `err_irq` ← 1.
  - If `err_clr` and a new error occur in the same cycle, the set wins.
- The slave index is registered on leaving IDLE. `m_addr` is required stable while `m_valid` = 1.

## Timing
- Reset values: state = IDLE, `cnt` = 0, `tmo` = 0, `err_irq` = 0, `err_addr` = 0.
  - `m_ready`, `s_sel` and `s_wstrb` are 0 during and after reset until `m_valid`.
  - `m_rdata` = 0 whenever `m_ready` = 0.
- Reset asserted mid-access: FSM returns to IDLE the next edge. No `m_ready` is issued for the aborted access.
- Latency, measured from the first `m_valid` cycle (cycle 0):
  - `WAIT` = 0: `m_ready` in cycle 0.
  - `WAIT` = n: `m_ready` in cycle n.
  - Handshake: `m_ready` in the cycle `s_ready` is first seen high.
  - Timeout: `m_ready` in cycle TIMEOUT if `s_ready` never rises.
- Throughput: one access per (latency + 2) cycles; the DONE cycle is always inserted.
- `err_irq` and `err_addr` update on the clock edge ending the error-completion cycle.

## Test plan
- NUM_SLAVES = 4, `WAIT` = {15, 2, 1, 0}; read 0x0000_0004 with `s_rdata[0]` = 0x1234 -> `m_ready` and `m_rdata` = 0x1234 in cycle 0. DONE next cycle with `s_sel` = 0.
- Write 0x0000_1000 with `m_wstrb` = 4'b0011 -> `s_sel` = 4'b0010 and `s_wstrb[7:4]` = 4'b0011 held for 2 cycles. `m_ready` in cycle 1. All other strobes 0.
- Read 0x0000_3000 with `s_ready[3]` rising in cycle 5 -> `m_ready` in cycle 5 with slave data; `err_irq` stays 0.
- TIMEOUT = 8, `s_ready[3]` held 0, read 0x0000_3010 -> `m_ready` in cycle 8, `m_rdata` = 0xDEADBEEF, `err_irq` = 1, `err_addr` = 0x0000_3010.
- Read unmapped 0x0000_7000 while pulsing `err_clr` in the same cycle -> immediate `m_ready` with 0xDEADBEEF; `err_irq` = 1 (set wins); a later lone `err_clr` -> `err_irq` = 0.
- Assert `rst` in cycle 1 of a `WAIT` = 2 access -> no `m_ready`, all outputs at reset values. A following access to slave 0 completes normally.
